// File: rtl/word_frame_pkg.sv
// word_frame_pkg: shared definitions for the WBLVDS word framer.
// Holds the FSM state encoding, the default framing constants (the receive
// side imports the same strobe bytes) and a byte-select helper.
package word_frame_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRAIN = 2'd1,
    RUN   = 2'd2
  } wf_state_e;

  localparam logic [BYTE_W-1:0] STROBE_PAT1_DFLT = 8'h00;
  localparam logic [BYTE_W-1:0] STROBE_PAT2_DFLT = 8'h80;
  localparam int unsigned       TRAIN_WORDS_DFLT = 16;
  localparam logic [WORD_W-1:0] TRAIN_PAT_DFLT   = 16'hA55A;
  localparam logic [WORD_W-1:0] IDLE_WORD_DFLT   = 16'h0000;
  localparam int unsigned       FIFO_DEPTH_DFLT  = 2;

  // Phase 0 carries the high byte, phase 1 the low byte.
  function automatic logic [BYTE_W-1:0] lane_byte(input logic [WORD_W-1:0] word,
                                                  input logic              phase);
    return phase ? word[BYTE_W-1:0] : word[WORD_W-1:BYTE_W];
  endfunction

endpackage

// File: rtl/tx_word_fifo.sv
// tx_word_fifo: small synchronous input buffer for the word framer.
// First-word-fall-through head (dout is valid whenever !empty), registered
// occupancy count. Push while full and pop while empty are ignored; flush
// has priority over both.
// Ports: clk, reset (sync, active-high), push/din, pop/dout, flush,
//        full, empty.
module tx_word_fifo
  import word_frame_pkg::*;
#(
  parameter int unsigned DEPTH = FIFO_DEPTH_DFLT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // Pointer/count update; depth is a power of two so pointers wrap naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push && !full;
    do_pop   = pop && !empty;

    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/word_frame_tx.sv
// word_frame_tx: transmit-side word framer for the WBLVDS link.
// Takes 16-bit words over valid/ready and emits each as two bytes on the
// data lane (high byte first) with the strobe lane carrying PAT1/PAT2 in
// lockstep. After enable it sends TRAIN_WORDS training words, then live
// data, inserting IDLE_WORD whenever the buffer runs dry.
// Ports:
//   ser_clk, reset     byte clock, synchronous active-high reset
//   enable             link enable, only sampled at word boundaries
//   s_data/s_valid/s_ready  sample word handshake
//   lane_data/lane_strobe   bytes to the serializer lanes
//   lane_valid         lanes carry framed traffic (TRAIN or RUN)
//   link_up            FSM is in RUN
//   underflow          one-cycle pulse per inserted idle word
module word_frame_tx
  import word_frame_pkg::*;
#(
  parameter logic [BYTE_W-1:0] STROBE_PAT1 = STROBE_PAT1_DFLT,
  parameter logic [BYTE_W-1:0] STROBE_PAT2 = STROBE_PAT2_DFLT,
  parameter int unsigned       TRAIN_WORDS = TRAIN_WORDS_DFLT,
  parameter logic [WORD_W-1:0] TRAIN_PAT   = TRAIN_PAT_DFLT,
  parameter logic [WORD_W-1:0] IDLE_WORD   = IDLE_WORD_DFLT,
  parameter int unsigned       FIFO_DEPTH  = FIFO_DEPTH_DFLT
) (
  input  logic              ser_clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [BYTE_W-1:0] lane_data,
  output logic [BYTE_W-1:0] lane_strobe,
  output logic              lane_valid,
  output logic              link_up,
  output logic              underflow
);

  wf_state_e         state_q, state_d;
  logic              phase_q, phase_d;
  logic [CNT_W-1:0]  train_cnt_q, train_cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [BYTE_W-1:0] lane_data_q, lane_data_d;
  logic [BYTE_W-1:0] lane_strobe_q, lane_strobe_d;
  logic              lane_valid_q, lane_valid_d;
  logic              link_up_q, link_up_d;
  logic              underflow_q, underflow_d;

  logic              fifo_push, fifo_pop, fifo_flush;
  logic              fifo_full, fifo_empty;
  logic [WORD_W-1:0] fifo_dout;

  // state_q and fifo_full are both flop outputs: no path from s_valid.
  assign s_ready   = (state_q != IDLE) && !fifo_full;
  assign fifo_push = s_valid && s_ready;

  tx_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (ser_clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   (s_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next-state, word load and output decode. Outputs are registered from the
  // next-state values so they line up with the word/phase they describe.
  always_comb begin
    phase_d     = ~phase_q;
    state_d     = state_q;
    train_cnt_d = train_cnt_q;
    word_d      = word_q;
    fifo_pop    = 1'b0;
    underflow_d = 1'b0;

    // phase_q==1 marks the word-boundary edge.
    if (phase_q) begin
      case (state_q)
        IDLE:    if (enable) state_d = TRAIN;
        TRAIN: begin
          if (!enable) begin
            state_d = IDLE;
          end else if (train_cnt_q == CNT_W'(TRAIN_WORDS - 1)) begin
            state_d = RUN;
          end
        end
        RUN:     if (!enable) state_d = IDLE;
        default: state_d = IDLE;
      endcase

      case (state_d)
        TRAIN: begin
          word_d      = TRAIN_PAT;
          train_cnt_d = (state_q == TRAIN) ? train_cnt_q + CNT_W'(1) : '0;
        end
        RUN: begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            word_d   = fifo_dout;
          end else begin
            word_d      = IDLE_WORD;
            underflow_d = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end

    // Holding the buffer flushed while idle also empties it on entry to IDLE.
    fifo_flush    = (state_d == IDLE);
    lane_valid_d  = (state_d != IDLE);
    link_up_d     = (state_d == RUN);
    lane_data_d   = lane_valid_d ? lane_byte(word_d, phase_d) : '0;
    lane_strobe_d = lane_valid_d ? (phase_d ? STROBE_PAT2 : STROBE_PAT1) : '0;
  end

  always_ff @(posedge ser_clk) begin
    if (reset) begin
      state_q       <= IDLE;
      phase_q       <= 1'b0;
      train_cnt_q   <= '0;
      word_q        <= '0;
      lane_data_q   <= '0;
      lane_strobe_q <= '0;
      lane_valid_q  <= 1'b0;
      link_up_q     <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      train_cnt_q   <= train_cnt_d;
      word_q        <= word_d;
      lane_data_q   <= lane_data_d;
      lane_strobe_q <= lane_strobe_d;
      lane_valid_q  <= lane_valid_d;
      link_up_q     <= link_up_d;
      underflow_q   <= underflow_d;
    end
  end

  assign lane_data   = lane_data_q;
  assign lane_strobe = lane_strobe_q;
  assign lane_valid  = lane_valid_q;
  assign link_up     = link_up_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_word_frame_tx.sv
// tb_word_frame_tx: directed bench for word_frame_tx with TRAIN_WORDS=4 and
// FIFO_DEPTH=2. Expected lane bytes are queued as stimulus is planned and
// popped whenever the DUT reports lane_valid. Inline comments give the edge
// index counted from the last reset edge (R).
module tb_word_frame_tx;

  logic        ser_clk;
  logic        reset;
  logic        enable;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  lane_data;
  logic [7:0]  lane_strobe;
  logic        lane_valid;
  logic        link_up;
  logic        underflow;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] s;
  } lane_t;

  lane_t exp_q[$];
  int    total;
  int    bad;
  int    uf_cnt;
  int    uf0;

  word_frame_tx #(
    .TRAIN_WORDS (4),
    .FIFO_DEPTH  (2)
  ) dut (
    .ser_clk     (ser_clk),
    .reset       (reset),
    .enable      (enable),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .lane_data   (lane_data),
    .lane_strobe (lane_strobe),
    .lane_valid  (lane_valid),
    .link_up     (link_up),
    .underflow   (underflow)
  );

  initial ser_clk = 1'b0;
  always #5 ser_clk = ~ser_clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_word(input logic [15:0] w);
    lane_t e;
    e.d = w[15:8]; e.s = 8'h00; exp_q.push_back(e);
    e.d = w[7:0];  e.s = 8'h80; exp_q.push_back(e);
  endtask

  task automatic expect_train();
    repeat (4) expect_word(16'hA55A);
  endtask

  // Sample the current cycle at the falling edge, then advance to #1 after
  // the next rising edge.
  task automatic step();
    lane_t e;
    @(negedge ser_clk);
    if (underflow === 1'b1) uf_cnt++;
    if (lane_valid === 1'b1) begin
      total++;
      assert (exp_q.size() != 0) else begin
        bad++;
        $error("FAIL lane_extra: observed %h%h expected no traffic", lane_data, lane_strobe);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("lane_bytes", {lane_data, lane_strobe}, {e.d, e.s});
      end
    end
    @(posedge ser_clk);
    #1;
  endtask

  // Hold a word on the handshake until accepted, with a bounded wait.
  task automatic send(input logic [15:0] w);
    logic rdy;
    logic done;
    done    = 1'b0;
    s_data  = w;
    s_valid = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      rdy = s_ready;
      step();
      if (rdy) done = 1'b1;
    end
    s_valid = 1'b0;
    chk("send_accept", 16'(done), 16'h0001);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_bytes"}, {lane_data, lane_strobe}, 16'h0000);
    chk({tag, "_flags"}, {12'h000, lane_valid, link_up, underflow, s_ready}, 16'h0000);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    uf_cnt  = 0;
    reset   = 1'b1;
    enable  = 1'b0;
    s_valid = 1'b0;
    s_data  = 16'h0000;

    repeat (3) step();
    reset = 1'b0;                                   // R
    check_quiet("reset");
    for (int i = 0; i < 10; i++) begin
      step();
      check_quiet("idle");
    end                                             // R+10

    // Training burst: enable seen on a phase-0 edge, so two cycles of latency.
    enable = 1'b1;
    expect_train();
    step();                                         // R+11
    chk("train_latency", 16'(lane_valid), 16'h0000);
    step();                                         // R+12
    chk("train_start", {13'h0, lane_valid, link_up, s_ready}, 16'h0005);
    repeat (2) step();                              // R+14

    // A word accepted during training becomes the first RUN word.
    expect_word(16'h1111);
    send(16'h1111);                                 // R+15
    repeat (4) step();                              // R+19
    chk("link_up_before", 16'(link_up), 16'h0000);
    step();                                         // R+20
    chk("link_up_after", 16'(link_up), 16'h0001);
    step();                                         // R+21

    // Back-to-back words; the first lands just after an idle word is chosen.
    expect_word(16'h0000);
    expect_word(16'h1234);
    expect_word(16'hBEEF);
    repeat (3) expect_word(16'h0000);
    expect_word(16'hCAFE);
    send(16'h1234);                                 // R+22
    send(16'hBEEF);                                 // R+23
    chk("ready_full", 16'(s_ready), 16'h0000);
    step();                                         // R+24
    chk("ready_back", 16'(s_ready), 16'h0001);
    repeat (3) step();                              // R+27

    // Three idle words with one underflow pulse each.
    uf0 = uf_cnt;
    repeat (5) step();                              // R+32
    send(16'hCAFE);                                 // R+33
    chk("underflow_pulses", 16'(uf_cnt - uf0), 16'h0003);
    step();                                         // R+34

    // Drop enable during CA; FE still goes out and DEAD must be flushed.
    enable = 1'b0;
    send(16'hDEAD);                                 // R+35
    chk("low_byte_valid", 16'(lane_valid), 16'h0001);
    step();                                         // R+36
    check_quiet("disabled");
    step();                                         // R+37

    // Re-enable: training restarts, then RUN finds an empty buffer.
    enable = 1'b1;
    expect_train();
    begin
      lane_t e;
      e.d = 8'h00; e.s = 8'h00;
      exp_q.push_back(e);
    end
    repeat (9) step();                              // R+46
    chk("flushed_run", {14'h0, link_up, underflow}, 16'h0003);

    // Reset in the middle of a word.
    reset = 1'b1;
    step();                                         // R+47 = R'
    check_quiet("mid_reset");
    reset = 1'b0;
    expect_train();
    expect_word(16'h0000);
    step();                                         // R'+1
    chk("restart_phase", 16'(lane_valid), 16'h0000);
    step();                                         // R'+2
    chk("restart_train", {lane_valid, 7'h0, lane_data}, 16'h80A5);
    repeat (8) step();                              // R'+10
    enable = 1'b0;
    step();                                         // R'+11
    step();                                         // R'+12
    check_quiet("final_idle");
    repeat (2) step();
    chk("sb_drain", 16'(exp_q.size()), 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
